// File: rtl/bus_arbiter.sv
// Round-robin arbiter that lets N_M masters share one register peripheral.
// Each accepted transaction runs IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
module bus_arbiter #(
  parameter int N_M = 3,
  parameter int AW  = 2,
  parameter int DW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_M-1:0]    m_req,
  input  logic [N_M-1:0]    m_wr,
  input  logic [N_M*AW-1:0] m_addr,
  input  logic [N_M*DW-1:0] m_wdata,
  output logic [N_M-1:0]    m_gnt,
  output logic [N_M-1:0]    m_done,
  output logic [DW-1:0]     m_rdata,
  output logic              busy,
  output logic              per_wr_en,
  output logic              per_rd_en,
  output logic [AW-1:0]     per_addr,
  output logic [DW-1:0]     per_wdata,
  input  logic [DW-1:0]     per_rdata
);

  localparam int IW = (N_M > 1) ? $clog2(N_M) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, win_reg, pick;
  logic            pick_valid;
  logic            wr_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg, rdata_reg;

  // Scan distances N_M down to 1 so the nearest requester after ptr is kept.
  always_comb begin
    int idx;
    logic [IW-1:0] idx_b;
    pick       = ptr_reg;
    pick_valid = 1'b0;
    idx        = 0;
    idx_b      = '0;
    for (int i = N_M; i >= 1; i--) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N_M) idx = idx - N_M;
      idx_b = IW'(idx);
      if (m_req[idx_b]) begin
        pick       = idx_b;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    m_gnt      = '0;
    m_done     = '0;
    busy       = 1'b0;
    per_wr_en  = 1'b0;
    per_rd_en  = 1'b0;
    per_addr   = '0;
    per_wdata  = '0;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE) begin
      busy           = 1'b1;
      m_gnt[win_reg] = 1'b1;
      per_addr       = addr_reg;
      per_wdata      = wdata_reg;
    end
    if (state_reg == ISSUE) begin
      per_wr_en = wr_reg;
      per_rd_en = !wr_reg;
    end
    if (state_reg == RESP) m_done[win_reg] = 1'b1;
  end

  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= IW'(N_M - 1);
      win_reg   <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (pick_valid) begin
          ptr_reg   <= pick;
          win_reg   <= pick;
          wr_reg    <= m_wr[pick];
          addr_reg  <= m_addr[pick*AW +: AW];
          wdata_reg <= m_wdata[pick*DW +: DW];
        end
        CAPTURE: rdata_reg <= wr_reg ? '0 : per_rdata;
        RESP:    rdata_reg <= '0;
        default: ;
      endcase
    end
  end

  assign m_rdata = rdata_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised bench for bus_arbiter: a register-file peripheral plus a
// transaction-level round-robin model predicting every grant and read value.
module tb_bus_arbiter;
  localparam int N_M = 3;
  localparam int AW  = 2;
  localparam int DW  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_M-1:0]    m_req = '0, m_wr = '0;
  logic [N_M*AW-1:0] m_addr = '0;
  logic [N_M*DW-1:0] m_wdata = '0;
  logic [N_M-1:0]    m_gnt, m_done;
  logic [DW-1:0]     m_rdata, per_wdata, per_rdata;
  logic              busy, per_wr_en, per_rd_en;
  logic [AW-1:0]     per_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_M(N_M), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata),
    .busy(busy), .per_wr_en(per_wr_en), .per_rd_en(per_rd_en),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata)
  );

  // Peripheral: register file with registered read, 0 when not reading.
  logic [DW-1:0] per_mem [2**AW];
  initial begin
    per_rdata = '0;
    for (int i = 0; i < 2**AW; i++) per_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (per_wr_en) per_mem[per_addr] <= per_wdata;
    per_rdata <= per_rd_en ? per_mem[per_addr] : '0;
  end

  // What one transaction looks like, sampled at the four negedges after acceptance.
  typedef struct packed {
    logic [N_M-1:0] gnt_issue;
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [N_M-1:0] gnt_cap;
    logic [N_M-1:0] done;
    logic [DW-1:0]  rdata;
    logic [N_M-1:0] done_other;
    logic           busy_idle;
    logic [N_M-1:0] gnt_idle;
  } obs_t;

  int            model_ptr;
  logic [DW-1:0] model_mem [2**AW];

  function automatic int model_pick(input logic [N_M-1:0] req);
    for (int d = 1; d <= N_M; d++) begin
      int c = (model_ptr + d) % N_M;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic obs_t model_txn(input logic [N_M-1:0] req, input logic [N_M-1:0] wr,
                                     input logic [N_M*AW-1:0] addr,
                                     input logic [N_M*DW-1:0] wdata);
    obs_t e;
    int w;
    logic [AW-1:0] a;
    e = '0;
    w = model_pick(req);
    model_ptr = w;
    a = addr[w*AW +: AW];
    e.gnt_issue = N_M'(1) << w;
    e.gnt_cap   = e.gnt_issue;
    e.done      = e.gnt_issue;
    e.wr_en     = wr[w];
    e.rd_en     = !wr[w];
    e.addr      = a;
    e.wdata     = wdata[w*DW +: DW];
    if (wr[w]) model_mem[a] = e.wdata;
    else       e.rdata = model_mem[a];
    return e;
  endfunction

  task automatic drive(input logic [N_M-1:0] req, input logic [N_M-1:0] wr,
                       input logic [N_M*AW-1:0] addr, input logic [N_M*DW-1:0] wdata);
    m_req = req; m_wr = wr; m_addr = addr; m_wdata = wdata;
  endtask

  // Observation only; callers compare. Optionally scrambles inputs after acceptance.
  task automatic collect(input bit drop, output obs_t o);
    o = '0;
    @(negedge clk);
    o.gnt_issue = m_gnt; o.wr_en = per_wr_en; o.rd_en = per_rd_en;
    o.addr = per_addr; o.wdata = per_wdata; o.done_other = m_done;
    if (drop) begin
      m_req = '0; m_wr = ~m_wr; m_addr = ~m_addr; m_wdata = ~m_wdata;
    end
    @(negedge clk);
    o.gnt_cap = m_gnt; o.done_other |= m_done;
    @(negedge clk);
    o.done = m_done; o.rdata = m_rdata;
    @(negedge clk);
    o.busy_idle = busy; o.gnt_idle = m_gnt; o.done_other |= m_done;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = N_M - 1;
  endtask

  // Cycle-by-cycle protocol invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((per_wr_en && per_rd_en) ||
          (!busy && (m_gnt != 0 || m_done != 0 || per_addr != 0 || per_wdata != 0 || m_rdata != 0)) ||
          (busy && $countones(m_gnt) != 1)) begin
        failures++;
        $display("FAIL protocol t=%0t gnt=%b done=%b busy=%b wr_en=%b rd_en=%b addr=%h wdata=%h rdata=%h required: strobes exclusive, idle outputs 0, one-hot grant when busy",
                 $time, m_gnt, m_done, busy, per_wr_en, per_rd_en, per_addr, per_wdata, m_rdata);
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_gnt, m_done, m_rdata, busy, per_wr_en, per_rd_en, per_addr, per_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b done=%b rdata=%h busy=%b wr=%b rd=%b addr=%h wdata=%h required all 0",
               m_gnt, m_done, m_rdata, busy, per_wr_en, per_rd_en, per_addr, per_wdata);
    end
    do_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset busy=%b required 0", busy);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    obs_t o, e;
    do_reset();
    drive(3'b001, 3'b001, {2'd0, 2'd0, 2'd2}, {4'h0, 4'h0, 4'hA});
    e = model_txn(m_req, m_wr, m_addr, m_wdata);
    collect(1'b0, o);
    $display("txn write: gnt=%b wr_en=%b addr=%h wdata=%h done=%b rdata=%h", o.gnt_issue, o.wr_en, o.addr, o.wdata, o.done, o.rdata);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL write_txn got %h required %h", o, e);
    end
    checks++;
    if (o.wr_en !== 1'b1 || o.addr !== 2'd2 || o.wdata !== 4'hA || o.done !== 3'b001 || o.rdata !== 4'h0) begin
      failures++;
      $display("FAIL write_fields got wr_en=%b addr=%h wdata=%h done=%b rdata=%h required 1 2 a 001 0",
               o.wr_en, o.addr, o.wdata, o.done, o.rdata);
    end
    drive(3'b010, 3'b000, {2'd0, 2'd2, 2'd0}, '0);
    e = model_txn(m_req, m_wr, m_addr, m_wdata);
    collect(1'b0, o);
    m_req = '0;
    $display("txn read: gnt=%b rd_en=%b addr=%h done=%b rdata=%h", o.gnt_issue, o.rd_en, o.addr, o.done, o.rdata);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL read_txn got %h required %h", o, e);
    end
    checks++;
    if (o.rd_en !== 1'b1 || o.done !== 3'b010 || o.rdata !== 4'hA) begin
      failures++;
      $display("FAIL read_fields got rd_en=%b done=%b rdata=%h required 1 010 a", o.rd_en, o.done, o.rdata);
    end
  endtask

  task automatic test_contention(input logic [N_M-1:0] req, input string name);
    obs_t o, e;
    int first = -1;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      int exp_w;
      drive(req, N_M'($urandom), (N_M*AW)'($urandom), (N_M*DW)'($urandom));
      exp_w = (req == 3'b111) ? t % 3 : ((t % 2 == 0) ? 0 : 2);
      e = model_txn(m_req, m_wr, m_addr, m_wdata);
      collect(1'b0, o);
      $display("txn %s %0d: gnt=%b done=%b rdata=%h", name, t, o.gnt_issue, o.done, o.rdata);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_txn%0d got %h required %h", name, t, o, e);
      end
      checks++;
      if (o.gnt_issue !== (N_M'(1) << exp_w)) begin
        failures++;
        $display("FAIL %s_order%0d got gnt=%b required master %0d", name, t, o.gnt_issue, exp_w);
      end
      if (first < 0) first = exp_w;
    end
    m_req = '0;
  endtask

  task automatic test_reset_abort();
    obs_t o, e;
    do_reset();
    drive(3'b001, 3'b001, {2'd0, 2'd0, 2'd1}, {4'h0, 4'h0, 4'h5});
    e = model_txn(m_req, m_wr, m_addr, m_wdata);
    collect(1'b0, o);
    drive(3'b001, 3'b000, {2'd0, 2'd0, 2'd1}, '0);
    @(negedge clk);  // ISSUE
    @(negedge clk);  // CAPTURE
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_gnt, m_done, m_rdata, busy, per_wr_en, per_rd_en, per_addr, per_wdata} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got gnt=%b done=%b rdata=%h busy=%b required all 0", m_gnt, m_done, m_rdata, busy);
    end
    m_req = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (m_done !== '0) begin
        failures++;
        $display("FAIL abort_no_done got done=%b required 000", m_done);
      end
    end
    rst_n = 1'b1;
    model_ptr = N_M - 1;
    drive(3'b110, 3'b000, {2'd1, 2'd1, 2'd1}, '0);
    e = model_txn(m_req, m_wr, m_addr, m_wdata);
    collect(1'b0, o);
    m_req = '0;
    $display("txn after abort: gnt=%b done=%b rdata=%h", o.gnt_issue, o.done, o.rdata);
    checks++;
    if (o !== e || o.gnt_issue !== 3'b010 || o.rdata !== 4'h5) begin
      failures++;
      $display("FAIL abort_first_grant got %h required %h (master 1, rdata 5)", o, e);
    end
  endtask

  task automatic test_req_drop();
    obs_t o, e;
    do_reset();
    drive(3'b100, 3'b100, {2'd3, 2'd0, 2'd0}, {4'h7, 4'h0, 4'h0});
    e = model_txn(m_req, m_wr, m_addr, m_wdata);
    collect(1'b1, o);
    $display("txn drop: gnt=%b wr_en=%b addr=%h wdata=%h done=%b", o.gnt_issue, o.wr_en, o.addr, o.wdata, o.done);
    checks++;
    if (o !== e || o.done !== 3'b100) begin
      failures++;
      $display("FAIL req_drop got %h required %h (done 100)", o, e);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        m_req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          checks++;
          if (busy !== 1'b0 || m_gnt !== '0) begin
            failures++;
            $display("FAIL idle_gap busy=%b gnt=%b required 0 000", busy, m_gnt);
          end
        end
      end
      drive(N_M'($urandom_range(1, 7)), N_M'($urandom), (N_M*AW)'($urandom), (N_M*DW)'($urandom));
      e = model_txn(m_req, m_wr, m_addr, m_wdata);
      collect(1'b0, o);
      $display("txn random %0d: req=%b gnt=%b wr_en=%b addr=%h wdata=%h done=%b rdata=%h",
               t, m_req, o.gnt_issue, o.wr_en, o.addr, o.wdata, o.done, o.rdata);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random_txn%0d got %h required %h", t, o, e);
      end
    end
    m_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_ptr = N_M - 1;
    for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
    test_reset();
    test_write_read();
    test_contention(3'b111, "contention");
    test_contention(3'b101, "fairness");
    test_reset_abort();
    test_req_drop();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
